// File: rtl/uart_stop_checker_p.sv
// -----------------------------------------------------------------------------
// uart_stop_checker_p
//
// Purpose:
//   Stop-bit checker for a UART receiver. When the deserialiser pulses
//   check_stop, the payload on RX_DATA is captured and the serial line is
//   watched for STOP_BITS bit periods of OVS clocks each. Every stop bit is
//   sampled near the middle of its period. A low stop bit marks the frame as
//   a framing error, but the checker always runs the full stop phase before
//   reporting, so frame timing never depends on line content.
//
// Optional feature (macro UART_STOP_MAJORITY_EN):
//   Defined   : each stop bit is sampled at counter values OVS/2-1, OVS/2 and
//               OVS/2+1 and is good when at least two samples are high.
//   Undefined : each stop bit uses the single sample at OVS/2.
//   Ports and latency are identical in both builds.
//
// Parameters:
//   DATA_W    - payload width, 5..9
//   STOP_BITS - stop bits checked, 1 or 2
//   OVS       - clocks per bit period, 4..64
//
// Ports:
//   clk        in   single clock, rising edge
//   rst        in   asynchronous reset, active-high
//   check_stop in   one-cycle pulse starting the stop-bit phase
//   RX_in      in   serial line, idle high
//   RX_DATA    in   payload, valid while check_stop is high
//   RX_dataout out  checked payload (0 after a framing error), held between results
//   data_valid out  one-cycle pulse: frame good
//   stop_error out  one-cycle pulse: framing error
//   busy       out  high while the stop phase is being checked
//   err_cnt    out  saturating framing-error count, cleared by reset only
// -----------------------------------------------------------------------------
module uart_stop_checker_p #(
    parameter int DATA_W    = 8,
    parameter int STOP_BITS = 1,
    parameter int OVS       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              check_stop,
    input  logic              RX_in,
    input  logic [DATA_W-1:0] RX_DATA,
    output logic [DATA_W-1:0] RX_dataout,
    output logic              data_valid,
    output logic              stop_error,
    output logic              busy,
    output logic [7:0]        err_cnt
);

    localparam int CNT_W = $clog2(OVS);

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(OVS - 1);
    localparam logic [CNT_W-1:0] SAMPLE_PT = CNT_W'(OVS / 2);

    // The stop index only ever needs to distinguish bit 0 from bit 1.
    localparam logic LAST_IDX = (STOP_BITS == 2);

`ifdef UART_STOP_MAJORITY_EN
    localparam logic [CNT_W-1:0] MAJ_FIRST = CNT_W'(OVS / 2 - 1);
    localparam logic [CNT_W-1:0] MAJ_LAST  = CNT_W'(OVS / 2 + 1);
`endif

    typedef enum logic {
        IDLE  = 1'b0,
        CHECK = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_stop_idx;
    logic              r_err;
    logic [DATA_W-1:0] r_hold;
    logic [DATA_W-1:0] r_dataout;
    logic              r_data_valid;
    logic              r_stop_error;
    logic [7:0]        r_err_cnt;

`ifdef UART_STOP_MAJORITY_EN
    // Number of low samples already seen within the current stop bit.
    logic [1:0]        r_low_cnt;
`endif

    // -------------------------------------------------------------------------
    // Combinational signals
    // -------------------------------------------------------------------------
    state_t            w_state_next;
    logic              w_accept;
    logic              w_done;
    logic              w_bit_end;
    logic              w_bad_bit;
    logic              w_err_next;

`ifdef UART_STOP_MAJORITY_EN
    logic [1:0]        w_low_total;
`endif

    assign w_bit_end = (r_cnt == LAST_CNT);

    // -------------------------------------------------------------------------
    // Stop-bit judgement. w_bad_bit is asserted in the cycle where the verdict
    // for the current stop bit becomes known. The verdict is folded into the
    // sticky flag combinationally so that a verdict landing on the completing
    // edge (majority mode with OVS=4) still reaches the result.
    // -------------------------------------------------------------------------
`ifdef UART_STOP_MAJORITY_EN
    assign w_low_total = r_low_cnt + {1'b0, ~RX_in};
    assign w_bad_bit   = (r_state == CHECK) && (r_cnt == MAJ_LAST) && (w_low_total >= 2'd2);
`else
    assign w_bad_bit   = (r_state == CHECK) && (r_cnt == SAMPLE_PT) && !RX_in;
`endif

    assign w_err_next = r_err | w_bad_bit;

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge value of every other register, independent of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every signal written here gets a default first; a path that left
    // one unassigned would infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_done       = 1'b0;

        case (r_state)
            IDLE: begin
                if (check_stop) begin
                    w_accept     = 1'b1;
                    w_state_next = CHECK;
                end
            end

            CHECK: begin
                // check_stop is deliberately not looked at here, including on
                // the completing edge; it is honoured again once back in IDLE.
                if (w_bit_end && (r_stop_idx == LAST_IDX)) begin
                    w_done       = 1'b1;
                    w_state_next = IDLE;
                end
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath: bit timing, sticky error, result registers
    // -------------------------------------------------------------------------
    // NOTE: the hold register is a plain register rather than a memory, so it
    // is reset along with everything else and never leaks a stale payload.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt        <= '0;
            r_stop_idx   <= 1'b0;
            r_err        <= 1'b0;
            r_hold       <= '0;
            r_dataout    <= '0;
            r_data_valid <= 1'b0;
            r_stop_error <= 1'b0;
            r_err_cnt    <= 8'd0;
        end else begin
            // Result strobes are single-cycle by construction.
            r_data_valid <= 1'b0;
            r_stop_error <= 1'b0;

            if (w_accept) begin
                r_hold     <= RX_DATA;
                r_cnt      <= '0;
                r_stop_idx <= 1'b0;
                r_err      <= 1'b0;
            end else if (r_state == CHECK) begin
                r_err <= w_err_next;

                if (w_done) begin
                    r_cnt      <= '0;
                    r_stop_idx <= 1'b0;
                end else if (w_bit_end) begin
                    r_cnt      <= '0;
                    r_stop_idx <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + CNT_ONE;
                end
            end

            if (w_done) begin
                if (w_err_next) begin
                    r_stop_error <= 1'b1;
                    r_dataout    <= '0;
                    if (r_err_cnt != 8'hFF) begin
                        r_err_cnt <= r_err_cnt + 8'd1;
                    end
                end else begin
                    r_data_valid <= 1'b1;
                    r_dataout    <= r_hold;
                end
            end
        end
    end

`ifdef UART_STOP_MAJORITY_EN
    // -------------------------------------------------------------------------
    // Majority vote accumulator: counts low samples at OVS/2-1 and OVS/2; the
    // third sample at OVS/2+1 is combined directly in w_low_total.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_low_cnt <= 2'd0;
        end else if (w_accept) begin
            r_low_cnt <= 2'd0;
        end else if (r_state == CHECK) begin
            if (w_bit_end) begin
                r_low_cnt <= 2'd0;
            end else if ((r_cnt == MAJ_FIRST) || (r_cnt == SAMPLE_PT)) begin
                r_low_cnt <= w_low_total;
            end
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign RX_dataout = r_dataout;
    assign data_valid = r_data_valid;
    assign stop_error = r_stop_error;
    assign busy       = (r_state == CHECK);
    assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_uart_stop_checker_p.sv
// -----------------------------------------------------------------------------
// tb_uart_stop_checker_p
//
// Two checker instances share one clock: unit 0 checks one stop bit, unit 1
// checks two. Each has its own inputs and reset. Frames are issued by tasks
// that push the expected result into a per-unit queue; a monitor on the
// falling edge pops and compares whenever a result pulse appears, and also
// tracks busy, the held RX_dataout and missing results.
// -----------------------------------------------------------------------------
module tb_uart_stop_checker_p;

    localparam int OVS    = 16;
    localparam int DATA_W = 8;
    localparam int HALF   = OVS / 2;

    typedef struct {
        int unsigned exp_cyc;   // cycle count at which the result is visible
        bit          good;
        logic [7:0]  data;      // expected RX_dataout at the result
        logic [7:0]  cnt;       // expected err_cnt at the result
        bit          discard;   // frame will be killed by reset
    } exp_t;

    logic              clk = 1'b0;
    logic              rst        [2];
    logic              cs         [2];
    logic              rx         [2];
    logic [DATA_W-1:0] din        [2];
    logic [DATA_W-1:0] dout       [2];
    logic              dv         [2];
    logic              se         [2];
    logic              bsy        [2];
    logic [7:0]        ecnt       [2];

    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    exp_t        q0[$];
    exp_t        q1[$];
    int          model_err [2];
    logic [7:0]  model_out [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_stop_checker_p #(.DATA_W(DATA_W), .STOP_BITS(1), .OVS(OVS)) u_dut0 (
        .clk(clk), .rst(rst[0]), .check_stop(cs[0]), .RX_in(rx[0]),
        .RX_DATA(din[0]), .RX_dataout(dout[0]), .data_valid(dv[0]),
        .stop_error(se[0]), .busy(bsy[0]), .err_cnt(ecnt[0])
    );

    uart_stop_checker_p #(.DATA_W(DATA_W), .STOP_BITS(2), .OVS(OVS)) u_dut1 (
        .clk(clk), .rst(rst[1]), .check_stop(cs[1]), .RX_in(rx[1]),
        .RX_DATA(din[1]), .RX_dataout(dout[1]), .data_valid(dv[1]),
        .stop_error(se[1]), .busy(bsy[1]), .err_cnt(ecnt[1])
    );

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------
    task automatic check(input string name, input int u, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s unit%0d cyc=%0d: got 0x%0h expected 0x%0h", name, u, cyc, act, exp);
        end
    endtask

    task automatic flag_fail(input string name, input int u);
        checks++;
        errors++;
        $display("FAIL %s unit%0d cyc=%0d", name, u, cyc);
    endtask

    function automatic bit q_have(input int u);
        return (u == 0) ? (q0.size() != 0) : (q1.size() != 0);
    endfunction

    function automatic exp_t q_head(input int u);
        return (u == 0) ? q0[0] : q1[0];
    endfunction

    task automatic q_pop(input int u);
        if (u == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
    endtask

    task automatic q_push(input int u, input exp_t e);
        if (u == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic q_clear(input int u);
        if (u == 0) q0.delete();
        else        q1.delete();
    endtask

    // Reference rule: a frame is good when every stop bit reads high at the
    // middle of its period (or by 2-of-3 vote around the middle).
    function automatic bit frame_good(input logic [63:0] pat, input int nbits);
        for (int b = 0; b < nbits; b++) begin
            int base;
            base = b * OVS;
`ifdef UART_STOP_MAJORITY_EN
            begin
                int highs;
                highs = int'(pat[base + HALF - 1]) + int'(pat[base + HALF]) + int'(pat[base + HALF + 1]);
                if (highs < 2) return 1'b0;
            end
`else
            if (!pat[base + HALF]) return 1'b0;
`endif
        end
        return 1'b1;
    endfunction

    function automatic logic [63:0] rand_pat(input int nbits);
        logic [63:0] p;
        int          mode;
        p    = '1;
        mode = int'($urandom_range(0, 3));
        case (mode)
            1: p[$urandom_range(0, nbits * OVS - 1)] = 1'b0;
            2: begin
                int start;
                int len;
                start = int'($urandom_range(0, nbits - 1)) * OVS + int'($urandom_range(HALF - 3, HALF + 2));
                len   = int'($urandom_range(1, 4));
                for (int j = 0; j < len; j++) p[start + j] = 1'b0;
            end
            3: for (int k = 0; k < nbits * OVS; k++) if ($urandom_range(0, 3) == 0) p[k] = 1'b0;
            default: ;
        endcase
        return p;
    endfunction

    // -------------------------------------------------------------------------
    // Reset one unit; outputs must drop immediately.
    // -------------------------------------------------------------------------
    task automatic reset_unit(input int u);
        rst[u] = 1'b1;
        cs[u]  = 1'b0;
        rx[u]  = 1'b1;
        q_clear(u);
        model_err[u] = 0;
        model_out[u] = '0;
        #1;
        check("rst_dataout", u, 32'(dout[u]), 32'd0);
        check("rst_valid",   u, 32'(dv[u]),   32'd0);
        check("rst_error",   u, 32'(se[u]),   32'd0);
        check("rst_busy",    u, 32'(bsy[u]),  32'd0);
        check("rst_errcnt",  u, 32'(ecnt[u]), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst[u] = 1'b0;
    endtask

    // -------------------------------------------------------------------------
    // Issue one frame. pat[k] is the line level while the bit counter is k
    // (stop bit k/OVS). extra[k] pulses check_stop during that cycle.
    // rst_at >= 0 asserts reset while the counter reads rst_at.
    // -------------------------------------------------------------------------
    task automatic run_frame(input int u, input logic [7:0] data, input logic [63:0] pat,
                             input logic [63:0] extra, input int rst_at);
        int   nbits;
        int   n;
        exp_t e;
        nbits  = (u == 0) ? 1 : 2;
        n      = nbits * OVS;
        cs[u]  = 1'b1;
        din[u] = data;
        rx[u]  = 1'b1;
        @(posedge clk);
        #1;
        cs[u]  = 1'b0;
        din[u] = 8'($urandom);
        e.exp_cyc = cyc + n;
        e.discard = (rst_at >= 0);
        e.good    = frame_good(pat, nbits);
        if (!e.discard && !e.good && model_err[u] < 255) model_err[u]++;
        e.cnt  = 8'(model_err[u]);
        e.data = e.good ? data : 8'h00;
        q_push(u, e);
        for (int k = 0; k < n; k++) begin
            if (k == rst_at) begin
                reset_unit(u);
                return;
            end
            rx[u] = pat[k];
            cs[u] = extra[k];
            @(posedge clk);
            #1;
        end
        rx[u] = 1'b1;
        cs[u] = 1'b0;
    endtask

    // -------------------------------------------------------------------------
    // Monitor
    // -------------------------------------------------------------------------
    task automatic monitor_unit(input int u);
        bit   have;
        exp_t h;
        have = q_have(u);
        if (have) h = q_head(u);
        check("busy", u, 32'(bsy[u]), 32'(have && (cyc < h.exp_cyc)));
        if (dv[u] || se[u]) begin
            if (dv[u] && se[u]) flag_fail("valid_and_error_together", u);
            if (!have || h.discard) begin
                flag_fail("unexpected_result", u);
            end else begin
                q_pop(u);
                check("latency",    u, cyc,            h.exp_cyc);
                check("data_valid", u, 32'(dv[u]),     32'(h.good));
                check("stop_error", u, 32'(se[u]),     32'(!h.good));
                check("dataout",    u, 32'(dout[u]),   32'(h.data));
                check("err_cnt",    u, 32'(ecnt[u]),   32'(h.cnt));
                model_out[u] = h.data;
            end
        end else begin
            if (have && cyc >= h.exp_cyc) begin
                flag_fail("missing_result", u);
                q_pop(u);
            end
            check("dataout_hold", u, 32'(dout[u]), 32'(model_out[u]));
        end
    endtask

    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) monitor_unit(u);
    end

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        for (int u = 0; u < 2; u++) begin
            rst[u] = 1'b1;
            cs[u]  = 1'b0;
            rx[u]  = 1'b1;
            din[u] = '0;
            model_err[u] = 0;
            model_out[u] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int u = 0; u < 2; u++) begin
            check("init_dataout", u, 32'(dout[u]), 32'd0);
            check("init_valid",   u, 32'(dv[u]),   32'd0);
            check("init_error",   u, 32'(se[u]),   32'd0);
            check("init_busy",    u, 32'(bsy[u]),  32'd0);
            check("init_errcnt",  u, 32'(ecnt[u]), 32'd0);
            rst[u] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;

        // Clean frame, single stop bit.
        run_frame(0, 8'hA5, '1, '0, -1);
        repeat (2) @(posedge clk);
        #1;
        // Line low for counter values 6..10: framing error.
        run_frame(0, 8'h3C, ~64'h7C0, '0, -1);
        // Back-to-back: accepted in the very next cycle after completion.
        run_frame(0, 8'h5A, '1, '0, -1);

        // Two stop bits, second low around its sample point, with extra
        // check_stop pulses mid-frame and on the completing edge.
        run_frame(1, 8'hC3, ~64'h380_0000, 64'h8010_0008, -1);
        run_frame(1, 8'h96, '1, 64'h8000_0000, -1);
        repeat (3) @(posedge clk);
        #1;

        // Single glitch at the sample point: build-dependent verdict.
        run_frame(0, 8'h77, ~64'h100, '0, -1);
        run_frame(1, 8'h11, ~64'h100_0100, '0, -1);

        // Reset while the counter reads 5; then a normal frame.
        run_frame(0, 8'hE7, '1, '0, 5);
        run_frame(0, 8'h81, '1, '0, -1);
        run_frame(1, 8'h42, '1, '0, 20);
        run_frame(1, 8'h24, '1, '0, -1);

        // Randomised frames.
        for (int i = 0; i < 60; i++) begin
            int          u;
            logic [63:0] extra;
            u     = int'($urandom_range(0, 1));
            extra = {$urandom & $urandom & $urandom, $urandom & $urandom & $urandom};
            run_frame(u, 8'($urandom), rand_pat(u + 1), extra, -1);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        // Saturation: 257 bad frames on unit 0, then a good and a bad one.
        reset_unit(0);
        for (int i = 0; i < 257; i++) run_frame(0, 8'($urandom), '0, '0, -1);
        repeat (2) @(posedge clk);
        #1;
        check("err_cnt_saturated", 0, 32'(ecnt[0]), 32'd255);
        run_frame(0, 8'hF0, '1, '0, -1);
        run_frame(0, 8'h0F, '0, '0, -1);

        // Drain and confirm nothing is outstanding.
        repeat (40) @(posedge clk);
        #1;
        check("queue0_empty", 0, 32'(q0.size()), 32'd0);
        check("queue1_empty", 1, 32'(q1.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
